// File: rtl/io_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : io_bus_arbiter
// Brief    : Round-robin two-master arbiter that sequences single-cycle
//            chip-select transactions onto the memory-mapped I/O controller.
// Revision : 1.0 - initial release
// ============================================================================
module io_bus_arbiter #(
    parameter int READ_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [4:0]  m0_address,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [4:0]  m1_address,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic        io_cs,
    output logic        io_we,
    output logic [4:0]  io_address,
    output logic [31:0] io_wdata,
    input  logic [31:0] io_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_ACK    = 2'd3
    } state_t;

    localparam logic [3:0] c_WAIT_INIT = 4'(READ_LATENCY - 1);

    state_t      r_state,      w_state;
    logic        r_last_grant, w_last_grant;
    logic        r_grant,      w_grant;
    logic        r_is_write,   w_is_write;
    logic [3:0]  r_wait_cnt,   w_wait_cnt;
    logic        r_io_cs,      w_io_cs;
    logic        r_io_we,      w_io_we;
    logic [4:0]  r_io_address, w_io_address;
    logic [31:0] r_io_wdata,   w_io_wdata;
    logic        r_m0_ack,     w_m0_ack;
    logic        r_m1_ack,     w_m1_ack;
    logic [31:0] r_m0_rdata,   w_m0_rdata;
    logic [31:0] r_m1_rdata,   w_m1_rdata;
    logic        r_busy,       w_busy;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_is_write   <= 1'b0;
            r_wait_cnt   <= 4'd0;
            r_io_cs      <= 1'b0;
            r_io_we      <= 1'b0;
            r_io_address <= 5'd0;
            r_io_wdata   <= 32'd0;
            r_m0_ack     <= 1'b0;
            r_m1_ack     <= 1'b0;
            r_m0_rdata   <= 32'd0;
            r_m1_rdata   <= 32'd0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_last_grant <= w_last_grant;
            r_grant      <= w_grant;
            r_is_write   <= w_is_write;
            r_wait_cnt   <= w_wait_cnt;
            r_io_cs      <= w_io_cs;
            r_io_we      <= w_io_we;
            r_io_address <= w_io_address;
            r_io_wdata   <= w_io_wdata;
            r_m0_ack     <= w_m0_ack;
            r_m1_ack     <= w_m1_ack;
            r_m0_rdata   <= w_m0_rdata;
            r_m1_rdata   <= w_m1_rdata;
            r_busy       <= w_busy;
        end
    end

    always_comb begin
        w_state      = r_state;
        w_last_grant = r_last_grant;
        w_grant      = r_grant;
        w_is_write   = r_is_write;
        w_wait_cnt   = r_wait_cnt;
        w_io_cs      = 1'b0;
        w_io_we      = 1'b0;
        w_io_address = r_io_address;
        w_io_wdata   = r_io_wdata;
        w_m0_ack     = 1'b0;
        w_m1_ack     = 1'b0;
        w_m0_rdata   = r_m0_rdata;
        w_m1_rdata   = r_m1_rdata;

        case (r_state)
            S_IDLE: begin
                if (m0_req || m1_req) begin
                    // Master 1 wins alone, or under contention when master 0 was served last.
                    w_grant      = m1_req && (!m0_req || !r_last_grant);
                    w_last_grant = w_grant;
                    w_is_write   = w_grant ? m1_we      : m0_we;
                    w_io_address = w_grant ? m1_address : m0_address;
                    w_io_wdata   = w_grant ? m1_wdata   : m0_wdata;
                    w_io_we      = w_is_write;
                    w_io_cs      = 1'b1;
                    w_state      = S_ACCESS;
                end
            end

            S_ACCESS: begin
                if (r_is_write) begin
                    w_m0_ack = !r_grant;
                    w_m1_ack = r_grant;
                    w_state  = S_ACK;
                end else begin
                    w_wait_cnt = c_WAIT_INIT;
                    w_state    = S_WAIT;
                end
            end

            S_WAIT: begin
                // io_rdata is only valid on the edge where the count expires.
                if (r_wait_cnt == 4'd0) begin
                    if (r_grant) begin
                        w_m1_rdata = io_rdata;
                        w_m1_ack   = 1'b1;
                    end else begin
                        w_m0_rdata = io_rdata;
                        w_m0_ack   = 1'b1;
                    end
                    w_state = S_ACK;
                end else begin
                    w_wait_cnt = r_wait_cnt - 4'd1;
                end
            end

            S_ACK: begin
                w_state = S_IDLE;
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase

        w_busy = (w_state != S_IDLE);
    end

    assign io_cs      = r_io_cs;
    assign io_we      = r_io_we;
    assign io_address = r_io_address;
    assign io_wdata   = r_io_wdata;
    assign m0_ack     = r_m0_ack;
    assign m1_ack     = r_m1_ack;
    assign m0_rdata   = r_m0_rdata;
    assign m1_rdata   = r_m1_rdata;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_io_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_bus_arbiter
// Brief    : Self-checking bench for io_bus_arbiter at READ_LATENCY 1 and 3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_bus_arbiter;

    localparam int N = 2;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst_v     [N];
    logic        req_v     [N][2];
    logic        we_v      [N][2];
    logic [4:0]  addr_v    [N][2];
    logic [31:0] wdata_v   [N][2];
    logic [31:0] rsp_v     [N];
    wire         ack_v     [N][2];
    wire  [31:0] rdata_v   [N][2];
    wire         cs_v      [N];
    wire         iowe_v    [N];
    wire  [4:0]  ioaddr_v  [N];
    wire  [31:0] iowdata_v [N];
    wire         busy_v    [N];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        logic [31:0] io_rdata_l = 'x;
        logic [15:0] cs_hist    = 16'd0;

        io_bus_arbiter #(.READ_LATENCY(g == 0 ? 1 : 3)) u_dut (
            .clock      (clock),
            .reset      (rst_v[g]),
            .m0_req     (req_v[g][0]),
            .m0_we      (we_v[g][0]),
            .m0_address (addr_v[g][0]),
            .m0_wdata   (wdata_v[g][0]),
            .m0_ack     (ack_v[g][0]),
            .m0_rdata   (rdata_v[g][0]),
            .m1_req     (req_v[g][1]),
            .m1_we      (we_v[g][1]),
            .m1_address (addr_v[g][1]),
            .m1_wdata   (wdata_v[g][1]),
            .m1_ack     (ack_v[g][1]),
            .m1_rdata   (rdata_v[g][1]),
            .io_cs      (cs_v[g]),
            .io_we      (iowe_v[g]),
            .io_address (ioaddr_v[g]),
            .io_wdata   (iowdata_v[g]),
            .io_rdata   (io_rdata_l),
            .busy       (busy_v[g])
        );

        // I/O controller: data valid only in the cycle READ_LATENCY cycles after select.
        always @(negedge clock) begin
            io_rdata_l = cs_hist[lat_of(g) - 1] ? rsp_v[g] : 32'hxxxx_xxxx;
            cs_hist    = {cs_hist[14:0], cs_v[g]};
        end
    end

    // Transaction-timeline model: t counts cycles since the grant edge (0 = idle).
    int          t_m     [N];
    bit          last_m  [N];
    bit          mst_m   [N];
    bit          we_m    [N];
    logic [4:0]  addr_m  [N];
    logic [31:0] wd_m    [N];
    logic [31:0] rd_m    [N][2];
    bit          armed_m [N];

    initial begin
        for (int g = 0; g < N; g++) begin
            t_m[g] = 0; last_m[g] = 1'b1; mst_m[g] = 1'b0; we_m[g] = 1'b0;
            addr_m[g] = '0; wd_m[g] = '0; rd_m[g][0] = '0; rd_m[g][1] = '0;
            armed_m[g] = 1'b0;
        end
    end

    always @(negedge clock) begin
        for (int g = 0; g < N; g++) begin
            int d;
            string p;
            d = we_m[g] ? 2 : lat_of(g) + 2;
            p = $sformatf("u%0d.", g);
            if (armed_m[g]) begin
                check({p, "io_cs"},      cs_v[g],      32'(t_m[g] == 1));
                check({p, "io_we"},      iowe_v[g],    32'(t_m[g] == 1 && we_m[g]));
                check({p, "io_address"}, ioaddr_v[g],  32'(addr_m[g]));
                check({p, "io_wdata"},   iowdata_v[g], wd_m[g]);
                check({p, "busy"},       busy_v[g],    32'(t_m[g] != 0));
                check({p, "m0_ack"},     ack_v[g][0],  32'(t_m[g] == d && !mst_m[g]));
                check({p, "m1_ack"},     ack_v[g][1],  32'(t_m[g] == d && mst_m[g]));
                check({p, "m0_rdata"},   rdata_v[g][0], rd_m[g][0]);
                check({p, "m1_rdata"},   rdata_v[g][1], rd_m[g][1]);
            end
            if (rst_v[g]) begin
                t_m[g] = 0; last_m[g] = 1'b1; we_m[g] = 1'b0;
                addr_m[g] = '0; wd_m[g] = '0; rd_m[g][0] = '0; rd_m[g][1] = '0;
                armed_m[g] = 1'b1;
            end else if (t_m[g] == 0) begin
                if (req_v[g][0] || req_v[g][1]) begin
                    if (req_v[g][0] && req_v[g][1]) mst_m[g] = !last_m[g];
                    else                            mst_m[g] = req_v[g][1];
                    last_m[g] = mst_m[g];
                    we_m[g]   = we_v[g][mst_m[g]];
                    addr_m[g] = addr_v[g][mst_m[g]];
                    wd_m[g]   = wdata_v[g][mst_m[g]];
                    t_m[g]    = 1;
                end
            end else if (t_m[g] == d) begin
                t_m[g] = 0;
            end else begin
                t_m[g]++;
                if (t_m[g] == d && !we_m[g]) rd_m[g][mst_m[g]] = rsp_v[g];
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_txn(input int g, input int m, input logic we, input logic [4:0] a,
                          input logic [31:0] d, output int lat);
        we_v[g][m] = we; addr_v[g][m] = a; wdata_v[g][m] = d; req_v[g][m] = 1'b1;
        lat = 0;
        while (lat < 40 && ack_v[g][m] !== 1'b1) begin
            tick();
            lat++;
        end
        check($sformatf("u%0d.m%0d_ack_seen", g, m), ack_v[g][m], 1);
        req_v[g][m] = 1'b0;
    endtask

    initial begin
        int lat;
        int got [4];
        int n;
        for (int g = 0; g < N; g++) begin
            rst_v[g] = 1'b1; rsp_v[g] = '0;
            for (int m = 0; m < 2; m++) begin
                req_v[g][m] = 1'b0; we_v[g][m] = 1'b0; addr_v[g][m] = '0; wdata_v[g][m] = '0;
            end
        end
        repeat (3) tick();
        rst_v[0] = 1'b0; rst_v[1] = 1'b0;
        tick();
        check("reset.m0_rdata", rdata_v[0][0], 0);
        check("reset.busy", busy_v[0], 0);

        // Single write on the latency-1 instance.
        we_v[0][0] = 1'b1; addr_v[0][0] = 5'd0; wdata_v[0][0] = 32'h0000_000A; req_v[0][0] = 1'b1;
        tick();
        check("wr.io_cs", cs_v[0], 1);
        check("wr.io_we", iowe_v[0], 1);
        check("wr.io_wdata", iowdata_v[0], 32'h0000_000A);
        tick();
        check("wr.io_cs_drop", cs_v[0], 0);
        check("wr.m0_ack", ack_v[0][0], 1);
        check("wr.m0_rdata", rdata_v[0][0], 0);
        req_v[0][0] = 1'b0;
        tick();

        // Single read by m1, latency 1.
        rsp_v[0] = 32'h0000_0005;
        do_txn(0, 1, 1'b0, 5'd2, 32'd0, lat);
        check("rd1.ack_cycles", lat, 3);
        check("rd1.m1_rdata", rdata_v[0][1], 32'h0000_0005);
        check("rd1.m0_rdata", rdata_v[0][0], 0);
        tick();

        // Attributes change after the grant edge.
        we_v[0][0] = 1'b1; addr_v[0][0] = 5'd3; wdata_v[0][0] = 32'h0000_1111; req_v[0][0] = 1'b1;
        tick();
        check("attr.io_address", ioaddr_v[0], 3);
        we_v[0][0] = 1'b0; addr_v[0][0] = 5'd7; wdata_v[0][0] = 32'h0000_2222;
        tick();
        check("attr.io_address_held", ioaddr_v[0], 3);
        check("attr.io_wdata_held", iowdata_v[0], 32'h0000_1111);
        check("attr.m0_ack", ack_v[0][0], 1);
        req_v[0][0] = 1'b0;
        tick();

        // Reset during WAIT of an m0 read.
        rsp_v[0] = 32'h0000_0077;
        we_v[0][0] = 1'b0; addr_v[0][0] = 5'd4; req_v[0][0] = 1'b1;
        tick();
        tick();
        check("rstmid.busy_in_wait", busy_v[0], 1);
        rst_v[0] = 1'b1;
        tick();
        check("rstmid.busy", busy_v[0], 0);
        check("rstmid.m0_ack", ack_v[0][0], 0);
        check("rstmid.m0_rdata", rdata_v[0][0], 0);
        check("rstmid.m1_rdata", rdata_v[0][1], 0);
        req_v[0][0] = 1'b0;
        rst_v[0] = 1'b0;
        tick();
        check("rstmid.no_late_ack", ack_v[0][0], 0);

        // Contention from reset: both held, grants must alternate starting with m0.
        for (int m = 0; m < 2; m++) begin
            we_v[0][m] = 1'b1; addr_v[0][m] = 5'(m + 1); wdata_v[0][m] = 32'(256 * (m + 1));
            req_v[0][m] = 1'b1;
        end
        for (int k = 0; k < 4; k++) got[k] = -1;
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            tick();
            if (ack_v[0][0] === 1'b1) begin got[n] = 0; n++; end
            else if (ack_v[0][1] === 1'b1) begin got[n] = 1; n++; end
        end
        req_v[0][0] = 1'b0; req_v[0][1] = 1'b0;
        for (int k = 0; k < 4; k++) check($sformatf("cont.grant%0d", k), got[k], k % 2);
        tick();

        // Latency-3 read on the second instance.
        rsp_v[1] = 32'hDEAD_BEEF;
        do_txn(1, 0, 1'b0, 5'd9, 32'd0, lat);
        check("rd3.ack_cycles", lat, 5);
        check("rd3.m0_rdata", rdata_v[1][0], 32'hDEAD_BEEF);
        check("rd3.m1_rdata", rdata_v[1][1], 0);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
